// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier: WIDTH+1 iterations on (WIDTH+1)-bit extended operands,
// signed or unsigned, with start/busy/done handshake and a truncation-overflow flag.
module seq_booth_mult #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam int XW    = WIDTH + 1;  // extended operand width
  localparam int AW    = WIDTH + 2;  // one guard bit so add/sub of any extended multiplicand never wraps
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [AW-1:0]      mcand;
  logic [AW-1:0]      acc;
  logic [XW-1:0]      q;
  logic               q_m1;
  logic [CNT_W-1:0]   cnt;
  logic               sm_q;

  logic [AW-1:0]      sum;
  logic [AW-1:0]      acc_nxt;
  logic [XW-1:0]      q_nxt;
  logic [2*WIDTH-1:0] prod_nxt;
  logic               ovf_nxt;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sum = acc;
    unique case ({q[0], q_m1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    acc_nxt  = {sum[AW-1], sum[AW-1:1]};
    q_nxt    = {sum[0], q[XW-1:1]};
    prod_nxt = {acc_nxt[WIDTH-2:0], q_nxt};
    ovf_nxt  = sm_q ? (prod_nxt[2*WIDTH-1:WIDTH] != {WIDTH{prod_nxt[WIDTH-1]}})
                    : (prod_nxt[2*WIDTH-1:WIDTH] != '0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
      mcand   <= '0;
      acc     <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      sm_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand <= signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
            q     <= {signed_mode & b[WIDTH-1], b};
            sm_q  <= signed_mode;
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= acc_nxt;
          q    <= q_nxt;
          q_m1 <= q[0];
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            product <= prod_nxt;
            ovf     <= ovf_nxt;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_booth_mult.sv
// Self-checking bench: directed handshake/reset/corner cases plus random regression at WIDTH=6, 8, 16,
// each result compared against plain integer multiplication.
module tb_seq_booth_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int W      = (gi == 0) ? 6 : (gi == 1) ? 8 : 16;
    localparam int N_RAND = 1500;

    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           sm = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic           ovf;
    logic           fin = 1'b0;

    seq_booth_mult #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm), .a(a), .b(b),
      .busy(busy), .done(done), .product(product), .ovf(ovf)
    );

    function automatic longint val(input logic [W-1:0] x, input logic s);
      logic signed [W-1:0] sx;
      sx = x;
      return s ? longint'(sx) : longint'(x);
    endfunction

    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                                  input logic s);
      return (2*W)'(val(x, s) * val(y, s));
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      longint p;
      longint half;
      p    = val(x, s) * val(y, s);
      half = longint'(1) <<< (W - 1);
      return s ? (p < -half || p >= half) : (p >= 2 * half);
    endfunction

    function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
        0:       return '0;
        1:       return '1;
        2:       return {1'b1, {(W-1){1'b0}}};
        default: return W'($urandom);
      endcase
    endfunction

    // Issues one multiply at posedge+1 and waits for done; operands are scrambled while busy.
    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic s, input string tag);
      int lat;
      logic [2*W-1:0] prev;
      prev  = product;
      start = 1'b1; a = ia; b = ib; sm = s;
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("w%0d %s busy", W, tag), 64'(busy), 64'(1));
      check($sformatf("w%0d %s held", W, tag), 64'(product), 64'(prev));
      a = W'($urandom); b = W'($urandom); sm = 1'($urandom);
      lat = 0;
      while (lat < W + 5) begin
        @(posedge clk); #1;
        lat++;
        if (done) break;
      end
      check($sformatf("w%0d %s lat", W, tag), 64'(lat), 64'(W + 1));
      check($sformatf("w%0d %s prod", W, tag), 64'(product), 64'(model_prod(ia, ib, s)));
      check($sformatf("w%0d %s ovf", W, tag), 64'(ovf), 64'(model_ovf(ia, ib, s)));
    endtask

    initial begin
      logic [W-1:0] ha, hb, mn;
      int ndone, dlat;
      mn = {1'b1, {(W-1){1'b0}}};

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check($sformatf("w%0d rst busy", W), 64'(busy), 64'(0));
      check($sformatf("w%0d rst done", W), 64'(done), 64'(0));
      check($sformatf("w%0d rst prod", W), 64'(product), 64'(0));
      check($sformatf("w%0d rst ovf", W), 64'(ovf), 64'(0));

      // Directed corners, issued back-to-back (start in each done cycle).
      op(W'(5), W'(-3), 1'b1, "5x-3");
      op(mn, mn, 1'b1, "minxmin");
      op('1, '1, 1'b0, "ones_u");
      op('1, '1, 1'b1, "ones_s");

      // Extra start pulses while busy must be ignored.
      ha = W'(11); hb = W'(-7);
      start = 1'b1; a = ha; b = hb; sm = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0; dlat = 0;
      for (int cyc = 1; cyc <= W + 4; cyc++) begin
        @(posedge clk); #1;
        if (done) begin
          ndone++;
          dlat = cyc;
        end
        start = (cyc == 1 || cyc == 4);  // sampled at RUN steps 2 and 5
        a = W'($urandom); b = W'($urandom); sm = 1'($urandom);
      end
      start = 1'b0;
      check($sformatf("w%0d hs ndone", W), 64'(ndone), 64'(1));
      check($sformatf("w%0d hs lat", W), 64'(dlat), 64'(W + 1));
      check($sformatf("w%0d hs prod", W), 64'(product), 64'(model_prod(ha, hb, 1'b1)));
      check($sformatf("w%0d hs busy", W), 64'(busy), 64'(0));

      // Reset in the middle of a run discards it.
      start = 1'b1; a = W'(9); b = W'(13); sm = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check($sformatf("w%0d mrst busy", W), 64'(busy), 64'(0));
      check($sformatf("w%0d mrst done", W), 64'(done), 64'(0));
      check($sformatf("w%0d mrst prod", W), 64'(product), 64'(0));
      check($sformatf("w%0d mrst ovf", W), 64'(ovf), 64'(0));
      ndone = 0;
      for (int cyc = 0; cyc < W + 3; cyc++) begin
        @(posedge clk); #1;
        if (done) ndone++;
      end
      check($sformatf("w%0d mrst nodone", W), 64'(ndone), 64'(0));
      op(W'(9), W'(13), 1'b0, "post_rst");

      for (int n = 0; n < N_RAND; n++) begin
        op(pick(), pick(), 1'($urandom), "rand");
      end
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_w[0].fin && g_w[1].fin && g_w[2].fin) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    check("all_finished", 64'(g_w[0].fin && g_w[1].fin && g_w[2].fin), 64'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
